// File: rtl/arm_pkg.sv
// Shared encodings for the ARM decode stage: ALU commands, opcodes, condition codes,
// instruction modes and the ID/EX pipeline payload.
package arm_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 15;
    localparam int unsigned REG_AW   = 4;
    localparam logic [3:0]  PC_IDX   = 4'd15;

    localparam logic [3:0] EXE_NOP     = 4'b0000;
    localparam logic [3:0] EXE_MOV     = 4'b0001;
    localparam logic [3:0] EXE_ADD     = 4'b0010;
    localparam logic [3:0] EXE_ADC     = 4'b0011;
    localparam logic [3:0] EXE_SUB     = 4'b0100;
    localparam logic [3:0] EXE_SBC     = 4'b0101;
    localparam logic [3:0] EXE_AND     = 4'b0110;
    localparam logic [3:0] EXE_ORR     = 4'b0111;
    localparam logic [3:0] EXE_EOR     = 4'b1000;
    localparam logic [3:0] EXE_MVN     = 4'b1001;
    localparam logic [3:0] EXE_CMP     = 4'b0100;
    localparam logic [3:0] EXE_TST     = 4'b0110;
    localparam logic [3:0] EXE_LDR_STR = 4'b0010;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_EOR     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b0010;
    localparam logic [3:0] OP_ADD     = 4'b0100;
    localparam logic [3:0] OP_ADC     = 4'b0101;
    localparam logic [3:0] OP_SBC     = 4'b0110;
    localparam logic [3:0] OP_TST     = 4'b1000;
    localparam logic [3:0] OP_CMP     = 4'b1010;
    localparam logic [3:0] OP_ORR     = 4'b1100;
    localparam logic [3:0] OP_MOV     = 4'b1101;
    localparam logic [3:0] OP_MVN     = 4'b1111;
    localparam logic [3:0] OP_LDR_STR = 4'b0100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] val_rn;
        logic [XLEN-1:0] val_rm;
        logic [3:0]      exe_cmd;
        logic            wb_en;
        logic            mem_r_en;
        logic            mem_w_en;
        logic            b;
        logic            s;
        logic            imm;
        logic [11:0]     shift_operand;
        logic [23:0]     signed_imm_24;
        logic [3:0]      dest;
    } idex_t;

    // Evaluate an ARM condition field against NZCV ([3]=N .. [0]=V).
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            COND_EQ: return z;
            COND_NE: return !z;
            COND_CS: return c;
            COND_CC: return !c;
            COND_MI: return n;
            COND_PL: return !n;
            COND_VS: return v;
            COND_VC: return !v;
            COND_HI: return c && !z;
            COND_LS: return !c || z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return !z && (n == v);
            COND_LE: return z || (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch/write-back inputs and ID/EX outputs of the decode stage, grouped as one bundle.
interface id_stage_if;
    import arm_pkg::*;

    logic            freeze;
    logic            flush;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] instruction;
    logic [3:0]      status;
    logic            wb_en;
    logic [3:0]      wb_dest;
    logic [XLEN-1:0] wb_value;

    logic [3:0]      src1;
    logic [3:0]      src2;
    logic            two_src;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] val_rn;
    logic [XLEN-1:0] val_rm;
    logic [3:0]      exe_cmd;
    logic            wb_en_out;
    logic            mem_r_en;
    logic            mem_w_en;
    logic            b_out;
    logic            s_out;
    logic            imm_out;
    logic [11:0]     shift_operand;
    logic [23:0]     signed_imm_24;
    logic [3:0]      dest;

    modport master (
        output freeze, flush, pc_in, instruction, status, wb_en, wb_dest, wb_value,
        input  src1, src2, two_src, pc_out, val_rn, val_rm, exe_cmd, wb_en_out,
               mem_r_en, mem_w_en, b_out, s_out, imm_out, shift_operand,
               signed_imm_24, dest
    );

    modport slave (
        input  freeze, flush, pc_in, instruction, status, wb_en, wb_dest, wb_value,
        output src1, src2, two_src, pc_out, val_rn, val_rm, exe_cmd, wb_en_out,
               mem_r_en, mem_w_en, b_out, s_out, imm_out, shift_operand,
               signed_imm_24, dest
    );

endinterface

// File: rtl/register_file.sv
// 15x32 GPR file, two combinational read ports with write-through bypass; index 15 reads the PC.
module register_file
    import arm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_c_o,
    output logic [XLEN-1:0]   rdata2_c_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != PC_IDX)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle write to the read index wins over the stored value.
    assign rdata1_c_o = (raddr1_i == PC_IDX)                ? pc_i    :
                        (we_i && (waddr_i == raddr1_i))     ? wdata_i :
                                                              regs_q[raddr1_i];
    assign rdata2_c_o = (raddr2_i == PC_IDX)                ? pc_i    :
                        (we_i && (waddr_i == raddr2_i))     ? wdata_i :
                                                              regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: decodes DP/LDR/STR/B, reads operands, checks the condition
// field and launches the result into the ID/EX register under freeze/flush control.
module id_stage
    import arm_pkg::*;
(
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);

    logic [1:0]      mode;
    logic [3:0]      opcode;
    logic            s_bit;
    logic            i_bit;
    logic            is_str;
    logic            cond_ok;
    logic [XLEN-1:0] val_rn_c;
    logic [XLEN-1:0] val_rm_c;

    logic [3:0]      exe_cmd_c;
    logic            wb_en_c;
    logic            mem_r_en_c;
    logic            mem_w_en_c;
    logic            b_c;
    logic            s_c;

    idex_t idex_d;
    idex_t idex_q;

    assign mode   = bus.instruction[27:26];
    assign opcode = bus.instruction[24:21];
    assign s_bit  = bus.instruction[20];
    assign i_bit  = bus.instruction[25];
    assign is_str = (mode == MODE_MEM) && (opcode == OP_LDR_STR) && !s_bit;

    // Hazard-unit view: never gated by condition, freeze or flush.
    assign bus.src1    = bus.instruction[19:16];
    assign bus.src2    = is_str ? bus.instruction[15:12] : bus.instruction[3:0];
    assign bus.two_src = !i_bit || is_str;

    register_file u_register_file (
        .clk        (clk),
        .rst        (rst),
        .we_i       (bus.wb_en),
        .waddr_i    (bus.wb_dest),
        .wdata_i    (bus.wb_value),
        .pc_i       (bus.pc_in),
        .raddr1_i   (bus.src1),
        .raddr2_i   (bus.src2),
        .rdata1_c_o (val_rn_c),
        .rdata2_c_o (val_rm_c)
    );

    assign cond_ok = cond_pass(bus.instruction[31:28], bus.status);

    // Control decode; unlisted encodings fall through as a NOP.
    always_comb begin
        exe_cmd_c  = EXE_NOP;
        wb_en_c    = 1'b0;
        mem_r_en_c = 1'b0;
        mem_w_en_c = 1'b0;
        b_c        = 1'b0;
        s_c        = 1'b0;
        case (mode)
            MODE_DP: begin
                wb_en_c = 1'b1;
                s_c     = s_bit;
                case (opcode)
                    OP_MOV:  exe_cmd_c = EXE_MOV;
                    OP_MVN:  exe_cmd_c = EXE_MVN;
                    OP_ADD:  exe_cmd_c = EXE_ADD;
                    OP_ADC:  exe_cmd_c = EXE_ADC;
                    OP_SUB:  exe_cmd_c = EXE_SUB;
                    OP_SBC:  exe_cmd_c = EXE_SBC;
                    OP_AND:  exe_cmd_c = EXE_AND;
                    OP_ORR:  exe_cmd_c = EXE_ORR;
                    OP_EOR:  exe_cmd_c = EXE_EOR;
                    OP_CMP: begin
                        exe_cmd_c = EXE_CMP;
                        wb_en_c   = 1'b0;
                    end
                    OP_TST: begin
                        exe_cmd_c = EXE_TST;
                        wb_en_c   = 1'b0;
                    end
                    default: begin
                        wb_en_c = 1'b0;
                        s_c     = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                if (opcode == OP_LDR_STR) begin
                    exe_cmd_c  = EXE_LDR_STR;
                    mem_r_en_c = s_bit;
                    wb_en_c    = s_bit;
                    mem_w_en_c = !s_bit;
                end
            end
            MODE_BR: b_c = 1'b1;
            default: ;
        endcase
    end

    // ID/EX next value: flush beats freeze; a failed condition only kills side effects.
    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d = '0;
        end else if (!bus.freeze) begin
            idex_d.pc            = bus.pc_in;
            idex_d.val_rn        = val_rn_c;
            idex_d.val_rm        = val_rm_c;
            idex_d.exe_cmd       = exe_cmd_c;
            idex_d.wb_en         = wb_en_c && cond_ok;
            idex_d.mem_r_en      = mem_r_en_c && cond_ok;
            idex_d.mem_w_en      = mem_w_en_c && cond_ok;
            idex_d.b             = b_c && cond_ok;
            idex_d.s             = s_c && cond_ok;
            idex_d.imm           = i_bit;
            idex_d.shift_operand = bus.instruction[11:0];
            idex_d.signed_imm_24 = bus.instruction[23:0];
            idex_d.dest          = bus.instruction[15:12];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.pc_out        = idex_q.pc;
    assign bus.val_rn        = idex_q.val_rn;
    assign bus.val_rm        = idex_q.val_rm;
    assign bus.exe_cmd       = idex_q.exe_cmd;
    assign bus.wb_en_out     = idex_q.wb_en;
    assign bus.mem_r_en      = idex_q.mem_r_en;
    assign bus.mem_w_en      = idex_q.mem_w_en;
    assign bus.b_out         = idex_q.b;
    assign bus.s_out         = idex_q.s;
    assign bus.imm_out       = idex_q.imm;
    assign bus.shift_operand = idex_q.shift_operand;
    assign bus.signed_imm_24 = idex_q.signed_imm_24;
    assign bus.dest          = idex_q.dest;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios plus randomized traffic against
// a table-driven reference model of the decode stage and register file.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  exe;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        b;
        logic        s;
        logic        imm;
        logic [11:0] shop;
        logic [23:0] simm;
        logic [3:0]  dest;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_rf [15];
    exp_t        m_idex;
    logic [3:0]  dp_exe   [16];
    bit          dp_valid [16];
    bit          dp_wb    [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t zero_idex();
        exp_t e;
        e.pc = '0; e.rn = '0; e.rm = '0; e.exe = '0;
        e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.b = 1'b0; e.s = 1'b0; e.imm = 1'b0;
        e.shop = '0; e.simm = '0; e.dest = '0;
        return e;
    endfunction

    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        bit n, z, c, v, ge;
        n = nzcv[3]; z = nzcv[2]; c = nzcv[1]; v = nzcv[0];
        ge = (n == v);
        case (cond)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !(c && !z);
            4'd10:   return ge;
            4'd11:   return !ge;
            4'd12:   return !z && ge;
            4'd13:   return !(!z && ge);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_store(input logic [31:0] ins);
        return ins[27:26] == 2'b01 && ins[24:21] == 4'b0100 && !ins[20];
    endfunction

    function automatic logic [31:0] rf_read(input logic [3:0] idx, input logic [31:0] pc,
                                            input logic we, input logic [3:0] wd,
                                            input logic [31:0] wv);
        if (idx == 4'd15) return pc;
        if (we && wd == idx) return wv;
        return m_rf[idx];
    endfunction

    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pc,
                                     input logic [3:0] st, input logic we,
                                     input logic [3:0] wd, input logic [31:0] wv);
        exp_t e;
        logic [3:0] op;
        e  = zero_idex();
        op = ins[24:21];
        e.pc   = pc;
        e.rn   = rf_read(ins[19:16], pc, we, wd, wv);
        e.rm   = rf_read(is_store(ins) ? ins[15:12] : ins[3:0], pc, we, wd, wv);
        e.imm  = ins[25];
        e.shop = ins[11:0];
        e.simm = ins[23:0];
        e.dest = ins[15:12];
        if (ins[27:26] == 2'b00 && dp_valid[op]) begin
            e.exe = dp_exe[op];
            e.wb  = dp_wb[op];
            e.s   = ins[20];
        end else if (ins[27:26] == 2'b01 && op == 4'b0100) begin
            e.exe = 4'b0010;
            e.mr  = ins[20];
            e.wb  = ins[20];
            e.mw  = !ins[20];
        end else if (ins[27:26] == 2'b10) begin
            e.b = 1'b1;
        end
        if (!cond_holds(ins[31:28], st)) begin
            e.wb = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.b = 1'b0; e.s = 1'b0;
        end
        return e;
    endfunction

    task automatic compare_outputs();
        check("pc_out",        bus.pc_out,               m_idex.pc);
        check("val_rn",        bus.val_rn,               m_idex.rn);
        check("val_rm",        bus.val_rm,               m_idex.rm);
        check("exe_cmd",       32'(bus.exe_cmd),         32'(m_idex.exe));
        check("wb_en_out",     32'(bus.wb_en_out),       32'(m_idex.wb));
        check("mem_r_en",      32'(bus.mem_r_en),        32'(m_idex.mr));
        check("mem_w_en",      32'(bus.mem_w_en),        32'(m_idex.mw));
        check("b_out",         32'(bus.b_out),           32'(m_idex.b));
        check("s_out",         32'(bus.s_out),           32'(m_idex.s));
        check("imm_out",       32'(bus.imm_out),         32'(m_idex.imm));
        check("shift_operand", 32'(bus.shift_operand),   32'(m_idex.shop));
        check("signed_imm_24", 32'(bus.signed_imm_24),   32'(m_idex.simm));
        check("dest",          32'(bus.dest),            32'(m_idex.dest));
    endtask

    // One clock of stimulus: drive, check the combinational view, clock, check ID/EX.
    task automatic step(input logic r, input logic frz, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] st,
                        input logic we, input logic [3:0] wd, input logic [31:0] wv);
        exp_t nxt;
        @(negedge clk);
        rst             = r;
        bus.freeze      = frz;
        bus.flush       = fl;
        bus.instruction = ins;
        bus.pc_in       = pc;
        bus.status      = st;
        bus.wb_en       = we;
        bus.wb_dest     = wd;
        bus.wb_value    = wv;
        #1;
        check("src1",    32'(bus.src1),    32'(ins[19:16]));
        check("src2",    32'(bus.src2),    32'(is_store(ins) ? ins[15:12] : ins[3:0]));
        check("two_src", 32'(bus.two_src), 32'(!ins[25] || is_store(ins)));
        if (r || fl)  nxt = zero_idex();
        else if (frz) nxt = m_idex;
        else          nxt = predict(ins, pc, st, we, wd, wv);
        @(posedge clk);
        #1;
        m_idex = nxt;
        if (r) begin
            for (int i = 0; i < 15; i++) m_rf[i] = '0;
        end else if (we && wd != 4'd15) begin
            m_rf[wd] = wv;
        end
        compare_outputs();
    endtask

    initial begin
        logic [31:0] ins;
        logic [1:0]  md;
        logic [3:0]  wd;

        for (int i = 0; i < 16; i++) begin
            dp_valid[i] = 1'b0; dp_wb[i] = 1'b0; dp_exe[i] = 4'd0;
        end
        // Mnemonic table: opcode -> ALU command, write-back flag.
        dp_exe[4'b1101] = 4'd1; dp_exe[4'b1111] = 4'd9; dp_exe[4'b0100] = 4'd2;
        dp_exe[4'b0101] = 4'd3; dp_exe[4'b0010] = 4'd4; dp_exe[4'b0110] = 4'd5;
        dp_exe[4'b0000] = 4'd6; dp_exe[4'b1100] = 4'd7; dp_exe[4'b0001] = 4'd8;
        dp_exe[4'b1010] = 4'd4; dp_exe[4'b1000] = 4'd6;
        foreach (dp_valid[i]) begin
            dp_valid[i] = (i == 13 || i == 15 || i == 4 || i == 5 || i == 2 || i == 6 ||
                           i == 0 || i == 12 || i == 1 || i == 10 || i == 8);
            dp_wb[i]    = dp_valid[i] && i != 10 && i != 8;
        end
        for (int i = 0; i < 15; i++) m_rf[i] = '0;
        m_idex = zero_idex();

        rst = 1'b1;
        bus.freeze = 1'b0; bus.flush = 1'b0; bus.instruction = '0; bus.pc_in = '0;
        bus.status = '0; bus.wb_en = 1'b0; bus.wb_dest = '0; bus.wb_value = '0;

        // Reset with a pending write that must be discarded.
        step(1, 0, 0, 32'hE0913001, 32'h40, 4'h0, 1, 4'd3, 32'hDEAD_BEEF);
        step(1, 0, 0, 32'hE0913001, 32'h44, 4'h0, 1, 4'd3, 32'hDEAD_BEEF);
        check("rst_exe_cmd", 32'(bus.exe_cmd), 32'd0);
        check("rst_pc_out",  bus.pc_out,       32'd0);
        step(0, 0, 0, 32'hE0830003, 32'h48, 4'h0, 0, 4'd0, 32'd0);
        check("r3_after_rst", bus.val_rn, 32'd0);

        // Write R1, then ADDS R3,R1,R1.
        step(0, 0, 0, 32'hE0830003, 32'h4C, 4'h0, 1, 4'd1, 32'h0000_1000);
        step(0, 0, 0, 32'hE0913001, 32'h50, 4'h0, 0, 4'd0, 32'd0);
        check("adds_val_rn", bus.val_rn,          32'h1000);
        check("adds_val_rm", bus.val_rm,          32'h1000);
        check("adds_exe",    32'(bus.exe_cmd),    32'h2);
        check("adds_s",      32'(bus.s_out),      32'd1);
        check("adds_wb",     32'(bus.wb_en_out),  32'd1);
        check("adds_dest",   32'(bus.dest),       32'd3);

        // NE condition with Z set, then clear.
        step(0, 0, 0, 32'h10011001, 32'h54, 4'b0100, 0, 4'd0, 32'd0);
        check("ne_z1_wb", 32'(bus.wb_en_out), 32'd0);
        step(0, 0, 0, 32'h10011001, 32'h58, 4'b0000, 0, 4'd0, 32'd0);
        check("ne_z0_wb", 32'(bus.wb_en_out), 32'd1);

        // STR R5,[R4] with a same-cycle write of R5.
        step(0, 0, 0, 32'hE4845000, 32'h5C, 4'h0, 1, 4'd5, 32'hFFFF_FF85);
        check("str_val_rm", bus.val_rm,         32'hFFFF_FF85);
        check("str_mem_w",  32'(bus.mem_w_en),  32'd1);

        // BLT taken, then flush the follower.
        step(0, 0, 0, 32'hBAFF_FFF7, 32'h60, 4'b1000, 0, 4'd0, 32'd0);
        check("blt_b",    32'(bus.b_out),         32'd1);
        check("blt_simm", 32'(bus.signed_imm_24), 32'hFF_FFF7);
        step(0, 0, 1, 32'hE0913001, 32'h64, 4'h0, 0, 4'd0, 32'd0);
        check("flush_wb",  32'(bus.wb_en_out), 32'd0);
        check("flush_exe", 32'(bus.exe_cmd),   32'd0);

        // Freeze holds ID/EX while the register file keeps writing.
        step(0, 0, 0, 32'hE0913001, 32'h100, 4'h0, 0, 4'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, $urandom, $urandom, 4'($urandom), 1, 4'(k + 6), $urandom);
            check("frz_pc_out", bus.pc_out,       32'h100);
            check("frz_dest",   32'(bus.dest),    32'd3);
        end
        step(0, 1, 1, 32'hE0913001, 32'h104, 4'h0, 0, 4'd0, 32'd0);
        check("frz_flush_wb", 32'(bus.wb_en_out), 32'd0);
        check("frz_flush_pc", bus.pc_out,          32'd0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            ins = $urandom;
            md  = 2'($urandom_range(0, 3));
            ins[27:26] = md;
            if (md == 2'b01 && $urandom_range(0, 3) != 0) ins[24:21] = 4'b0100;
            wd = ($urandom_range(0, 2) == 0) ? ins[19:16] : 4'($urandom);
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 9) == 0), ins, $urandom, 4'($urandom),
                 1'($urandom_range(0, 1)), wd, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
